// File: rtl/linalg_pkg.sv
// Shared types for the linalg datapath: word type, transpose FSM states and
// the counter-width helper used by the streaming transpose.
package linalg_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {ST_LOAD, ST_DRAIN} tr_state_t;

   // Counters must hold 0..max(M,N)-1 and never collapse below one bit.
   function automatic int cnt_width(input int m, input int n);
      int mx;
      mx = (m > n) ? m : n;
      if (mx < 2) mx = 2;
      return $clog2(mx);
   endfunction

endpackage

// File: rtl/mat_transpose_stream_if.sv
// Row-in / column-out stream bundle for mat_transpose_stream.
// The slave modport is the transpose engine, master is its environment.
interface mat_transpose_stream_if #(
   parameter int M = 2,
   parameter int N = 2
) ();
   import linalg_pkg::*;

   logic                          in_valid;
   logic                          in_ready;
   logic [N-1:0][WORD_W-1:0]      in_row;
   logic                          out_valid;
   logic                          out_ready;
   logic [M-1:0][WORD_W-1:0]      out_row;
   logic                          out_last;
   logic                          busy;

   modport slave (
      input  in_valid, in_row, out_ready,
      output in_ready, out_valid, out_row, out_last, busy
   );

   modport master (
      output in_valid, in_row, out_ready,
      input  in_ready, out_valid, out_row, out_last, busy
   );

endinterface

// File: rtl/mat_transpose.sv
// Purely combinational M x N -> N x M matrix transpose; words are rewired,
// never modified.
module mat_transpose
   import linalg_pkg::*;
#(
   parameter int M = 2,
   parameter int N = 2
) (
   input  logic [M-1:0][N-1:0][WORD_W-1:0] mat_in,
   output logic [N-1:0][M-1:0][WORD_W-1:0] mat_out
);

   for (genvar i = 0; i < M; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         assign mat_out[j][i] = mat_in[i][j];
      end
   end

endmodule

// File: rtl/mat_transpose_stream.sv
// Streaming transpose: loads M input rows into a single register buffer, then
// drains the N columns as output rows. LOAD and DRAIN never overlap.
module mat_transpose_stream
   import linalg_pkg::*;
#(
   parameter int M = 2,
   parameter int N = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   mat_transpose_stream_if.slave   bus
);

   localparam int CW = cnt_width(M, N);

   tr_state_t                        state;
   logic [CW-1:0]                    row_cnt;
   logic [CW-1:0]                    col_cnt;
   logic                             rdy_en;
   logic [M-1:0][N-1:0][WORD_W-1:0]  mat_buf;
   logic [N-1:0][M-1:0][WORD_W-1:0]  mat_t;
   logic [M-1:0][WORD_W-1:0]         out_mux;
   logic                             in_fire;
   logic                             out_fire;
   logic                             row_last;
   logic                             col_last;

   mat_transpose #(.M(M), .N(N)) u_transpose (
      .mat_in  (mat_buf),
      .mat_out (mat_t)
   );

   assign in_fire  = bus.in_valid && bus.in_ready;
   assign out_fire = bus.out_valid && bus.out_ready;
   assign row_last = (row_cnt == CW'(M - 1));
   assign col_last = (col_cnt == CW'(N - 1));

   assign bus.in_ready  = rdy_en && (state == ST_LOAD);
   assign bus.out_valid = (state == ST_DRAIN);
   assign bus.out_last  = (state == ST_DRAIN) && col_last;
   assign bus.busy      = (state == ST_DRAIN) || (row_cnt != '0);
   assign bus.out_row   = out_mux;

   // Compare-based select keeps the index width independent of N.
   always_comb begin
      out_mux = '0;
      for (int k = 0; k < N; k++) begin
         if (col_cnt == CW'(k)) out_mux = mat_t[k];
      end
   end

   // rdy_en delays in_ready by one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_LOAD;
         row_cnt <= '0;
         col_cnt <= '0;
         rdy_en  <= 1'b0;
         mat_buf <= '0;
      end else begin
         rdy_en <= 1'b1;
         case (state)
            ST_LOAD: begin
               if (in_fire) begin
                  for (int i = 0; i < M; i++) begin
                     if (row_cnt == CW'(i)) mat_buf[i] <= bus.in_row;
                  end
                  if (row_last) begin
                     row_cnt <= '0;
                     state   <= ST_DRAIN;
                  end else begin
                     row_cnt <= row_cnt + CW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (out_fire) begin
                  if (col_last) begin
                     col_cnt <= '0;
                     state   <= ST_LOAD;
                  end else begin
                     col_cnt <= col_cnt + CW'(1);
                  end
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_transpose_stream.sv
// Scoreboard bench for mat_transpose_stream: a 2x3 and a 1x1 instance driven
// with directed matrices; a negedge monitor pops expected rows on each output handshake.
module tb_mat_transpose_stream;
   import linalg_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   typedef struct { logic [1:0][31:0] row; logic last; } exp23_t;
   typedef struct { logic [31:0] row; logic last; } exp11_t;

   exp23_t q23[$];
   exp11_t q11[$];
   exp23_t e23;
   exp11_t e11;

   always #5 clk = ~clk;

   mat_transpose_stream_if #(.M(2), .N(3)) bus23 ();
   mat_transpose_stream_if #(.M(1), .N(1)) bus11 ();

   mat_transpose_stream #(.M(2), .N(3)) dut23 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus23)
   );

   mat_transpose_stream #(.M(1), .N(1)) dut11 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus11)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0][31:0] inRow(input int c0, input int c1, input int c2);
      logic [2:0][31:0] r;
      r[0] = 32'(c0);
      r[1] = 32'(c1);
      r[2] = 32'(c2);
      return r;
   endfunction

   function automatic logic [1:0][31:0] outRow(input int a0, input int a1);
      logic [1:0][31:0] r;
      r[0] = 32'(a0);
      r[1] = 32'(a1);
      return r;
   endfunction

   task automatic pushExp23(input int a0, input int a1, input logic last);
      exp23_t e;
      e.row  = outRow(a0, a1);
      e.last = last;
      q23.push_back(e);
   endtask

   // Input rows {a0,a1,a2},{b0,b1,b2} transpose to {a0,b0},{a1,b1},{a2,b2}.
   task automatic expectMatrix23(input int a0, input int a1, input int a2,
                                 input int b0, input int b1, input int b2);
      pushExp23(a0, b0, 1'b0);
      pushExp23(a1, b1, 1'b0);
      pushExp23(a2, b2, 1'b1);
   endtask

   task automatic pushExp11(input logic [31:0] v);
      exp11_t e;
      e.row  = v;
      e.last = 1'b1;
      q11.push_back(e);
   endtask

   // Holds one row on the 2x3 input until it is accepted; returns at edge + 1.
   task automatic applyStimulus23(input logic [2:0][31:0] row);
      int   n;
      logic taken;
      n = 0;
      bus23.in_valid = 1'b1;
      bus23.in_row   = row;
      do begin
         @(negedge clk);
         taken = bus23.in_ready;
         @(posedge clk);
         n++;
      end while (!taken && n < 50);
      #1;
      bus23.in_valid = 1'b0;
      if (!taken) checkOutput("in_handshake_timeout", 64'd0, 64'd1);
   endtask

   // Asserts reset (checking outputs while low), then releases it and checks the in_ready rise.
   task automatic resetCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_in_ready",  bus23.in_ready,  64'd0);
      checkOutput("rst_out_valid", bus23.out_valid, 64'd0);
      checkOutput("rst_out_last",  bus23.out_last,  64'd0);
      checkOutput("rst_busy",      bus23.busy,      64'd0);
      checkOutput("rst_out_row",   bus23.out_row,   64'd0);
      checkOutput("rst11_in_ready", bus11.in_ready, 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rel_in_ready_low", bus23.in_ready, 64'd0);
      @(posedge clk);
      #1;
      checkOutput("rel_in_ready_high", bus23.in_ready,  64'd1);
      checkOutput("rel_out_valid",     bus23.out_valid, 64'd0);
      checkOutput("rel_busy",          bus23.busy,      64'd0);
   endtask

   // Scoreboard monitors: compare on every output handshake.
   always @(negedge clk) begin
      if (rst_n && bus23.out_valid && bus23.out_ready) begin
         if (q23.size() == 0) begin
            checkOutput("sb23_unexpected_row", bus23.out_row, 64'd0 - 64'd1);
         end else begin
            e23 = q23.pop_front();
            checkOutput("sb23_row",  bus23.out_row,  e23.row);
            checkOutput("sb23_last", bus23.out_last, e23.last);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus11.out_valid && bus11.out_ready) begin
         if (q11.size() == 0) begin
            checkOutput("sb11_unexpected_row", bus11.out_row, 64'd0 - 64'd1);
         end else begin
            e11 = q11.pop_front();
            checkOutput("sb11_row",  bus11.out_row,  e11.row);
            checkOutput("sb11_last", bus11.out_last, e11.last);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      bus23.in_valid  = 1'b0;
      bus23.in_row    = '0;
      bus23.out_ready = 1'b1;
      bus11.in_valid  = 1'b0;
      bus11.in_row    = '0;
      bus11.out_ready = 1'b1;

      resetCycle();

      // Basic 2x3 with free-flowing output.
      expectMatrix23(1, 2, 3, 4, 5, 6);
      applyStimulus23(inRow(1, 2, 3));
      checkOutput("load_busy",     bus23.busy,      64'd1);
      checkOutput("load_no_valid", bus23.out_valid, 64'd0);
      applyStimulus23(inRow(4, 5, 6));
      checkOutput("drain_valid_rise",   bus23.out_valid, 64'd1);
      checkOutput("drain_in_ready_low", bus23.in_ready,  64'd0);
      checkOutput("drain_first_row",    bus23.out_row,   outRow(1, 4));
      repeat (3) @(posedge clk);
      #1;
      checkOutput("drain_consecutive", q23.size(),     64'd0);
      checkOutput("reload_in_ready",   bus23.in_ready, 64'd1);
      checkOutput("idle_busy",         bus23.busy,     64'd0);

      // Backpressure on the second output row.
      expectMatrix23(1, 2, 3, 4, 5, 6);
      applyStimulus23(inRow(1, 2, 3));
      applyStimulus23(inRow(4, 5, 6));
      @(posedge clk);
      #1;
      bus23.out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stall_row",      bus23.out_row,   outRow(2, 5));
         checkOutput("stall_valid",    bus23.out_valid, 64'd1);
         checkOutput("stall_in_ready", bus23.in_ready,  64'd0);
      end
      @(posedge clk);
      #1;
      bus23.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("stall_drained",  q23.size(),     64'd0);
      checkOutput("stall_in_ready", bus23.in_ready, 64'd1);

      // Input bubble during LOAD, held input ignored during DRAIN.
      expectMatrix23(20, 21, 22, 23, 24, 25);
      expectMatrix23(7, 8, 9, 30, 31, 32);
      bus23.in_valid = 1'b1;
      bus23.in_row   = inRow(20, 21, 22);
      @(posedge clk);
      #1;
      bus23.in_valid = 1'b0;
      bus23.in_row   = inRow(99, 98, 97);
      @(posedge clk);
      #1;
      checkOutput("bubble_busy", bus23.busy, 64'd1);
      bus23.in_valid = 1'b1;
      bus23.in_row   = inRow(23, 24, 25);
      @(posedge clk);
      #1;
      bus23.in_row = inRow(7, 8, 9);
      repeat (3) begin
         @(negedge clk);
         checkOutput("ignore_in_ready", bus23.in_ready, 64'd0);
         @(posedge clk);
      end
      #1;
      checkOutput("ignore_busy_idle", bus23.busy,     64'd0);
      checkOutput("ignore_ready_back", bus23.in_ready, 64'd1);
      @(posedge clk);
      #1;
      bus23.in_valid = 1'b0;
      checkOutput("held_row_taken", bus23.busy, 64'd1);
      applyStimulus23(inRow(30, 31, 32));
      repeat (3) @(posedge clk);
      #1;
      checkOutput("bubble_drained", q23.size(), 64'd0);

      // Degenerate 1x1: two matrices back to back, period 2.
      pushExp11(32'hDEADBEEF);
      pushExp11(32'h12345678);
      bus11.in_valid = 1'b1;
      bus11.in_row   = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      checkOutput("d11_valid",    bus11.out_valid, 64'd1);
      checkOutput("d11_last",     bus11.out_last,  64'd1);
      checkOutput("d11_in_ready", bus11.in_ready,  64'd0);
      checkOutput("d11_busy",     bus11.busy,      64'd1);
      bus11.in_row = 32'h12345678;
      @(posedge clk);
      #1;
      checkOutput("d11_reload_ready", bus11.in_ready,  64'd1);
      checkOutput("d11_reload_valid", bus11.out_valid, 64'd0);
      @(posedge clk);
      #1;
      bus11.in_valid = 1'b0;
      checkOutput("d11_second_valid", bus11.out_valid, 64'd1);
      @(posedge clk);
      #1;
      checkOutput("d11_done_valid", bus11.out_valid, 64'd0);
      checkOutput("d11_done_busy",  bus11.busy,      64'd0);
      checkOutput("d11_drained",    q11.size(),      64'd0);

      // Reset after one input row: partial matrix discarded.
      applyStimulus23(inRow(40, 41, 42));
      resetCycle();

      // Reset after one output row: only that row is expected.
      pushExp23(50, 53, 1'b0);
      applyStimulus23(inRow(50, 51, 52));
      applyStimulus23(inRow(53, 54, 55));
      @(posedge clk);
      #1;
      resetCycle();
      checkOutput("mid_drain_flushed", q23.size(), 64'd0);

      // Fresh matrix after reset.
      expectMatrix23(10, 11, 12, 13, 14, 15);
      applyStimulus23(inRow(10, 11, 12));
      applyStimulus23(inRow(13, 14, 15));
      repeat (3) @(posedge clk);
      #1;
      checkOutput("fresh_drained", q23.size(),  64'd0);
      checkOutput("fresh_busy",    bus23.busy,  64'd0);
      checkOutput("final_q11",     q11.size(),  64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
